// File: rtl/heatmap_frame_writer.sv
// Walks a ROWS x COLS grid, maps each signed fixed-point node value to an RGB332 colour and writes it to pixel memory.
// Optional build macro HEATMAP_MARKER_EN forces the pixel at (MARK_ROW, MARK_COL) to purple.
module heatmap_frame_writer #(
  parameter int COLS        = 64,
  parameter int ROWS        = 64,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int FRAC_BITS   = 27,
  parameter int WAIT_CYCLES = 2,
  parameter int MARK_ROW    = 0,
  parameter int MARK_COL    = 35
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              comp_allow,
  input  logic              start,
  output logic              val_req,
  output logic [ADDR_W-1:0] val_addr,
  input  logic [DATA_W-1:0] val_data,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [7:0]        write_data,
  output logic              busy,
  output logic              done_write_sig
);

  typedef enum logic [2:0] {
    IDLE, READ, CAPTURE, WRITE, WAIT, ADVANCE, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LIN_LAST  = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(COLS - 1);
  localparam logic [3:0]        WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t state, state_next;
  logic [ADDR_W-1:0] lin, row, col;
  logic [3:0] wait_cnt;
  logic [2:0] colour_idx;
  logic [7:0] colour;
  logic abort;

  assign abort = reset || comp_allow;

  function automatic logic [7:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 8'h03;
      3'd1:    palette = 8'h0F;
      3'd2:    palette = 8'h1F;
      3'd3:    palette = 8'h1C;
      3'd4:    palette = 8'h9C;
      3'd5:    palette = 8'hFC;
      3'd6:    palette = 8'hF0;
      default: palette = 8'hE0;
    endcase
  endfunction

  // Negative saturates to the coldest entry, >= 1.0 to the hottest; otherwise the top three fraction bits.
  always_comb begin
    colour_idx = val_data[FRAC_BITS-1 -: 3];
    if (val_data[DATA_W-1])
      colour_idx = 3'd0;
    else if (|val_data[DATA_W-2:FRAC_BITS])
      colour_idx = 3'd7;
  end

  logic unused_low_bits;
  assign unused_low_bits = ^val_data[FRAC_BITS-4:0];

`ifdef HEATMAP_MARKER_EN
  assign colour = (row == ADDR_W'(MARK_ROW) && col == ADDR_W'(MARK_COL)) ? 8'hE3 : palette(colour_idx);
`else
  logic unused_marker;
  assign unused_marker = (MARK_ROW == MARK_COL);
  assign colour = palette(colour_idx);
`endif

  always_ff @(posedge clk_50) begin
    if (abort)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk_50) begin
    if (abort || state == DONE) begin
      lin      <= '0;
      row      <= '0;
      col      <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == WRITE)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 4'd1;
      if (state == ADVANCE && lin != LIN_LAST) begin
        lin <= lin + 1'b1;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Write port registers keep their last value through an abort; only reset clears them.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      write_addr <= '0;
      write_data <= '0;
    end else if (state == CAPTURE && !comp_allow) begin
      write_addr <= lin;
      write_data <= colour;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !comp_allow) state_next = READ;
      READ:    state_next = CAPTURE;
      CAPTURE: state_next = WRITE;
      WRITE:   state_next = (WAIT_CYCLES > 0) ? WAIT : ADVANCE;
      WAIT:    if (wait_cnt == WAIT_LAST) state_next = ADVANCE;
      ADVANCE: state_next = (lin == LIN_LAST) ? DONE : READ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    val_req        = (state == READ);
    val_addr       = (state == READ) ? lin : '0;
    write_en       = (state == WRITE);
    busy           = (state != IDLE) && (state != DONE);
    done_write_sig = (state == DONE);
  end

endmodule
